// File: rtl/gpio_spi_regs_if.sv
// SPI pad bundle between the GPIO padframe and the serial register block.
// The master side is the external host; the slave side is gpio_spi_regs.
`timescale 1ns/1ps
interface gpio_spi_regs_if;
  logic spi_sck_i;
  logic spi_cs_n_i;
  logic spi_mosi_i;
  logic spi_miso_o;

  modport master (
    output spi_sck_i,
    output spi_cs_n_i,
    output spi_mosi_i,
    input  spi_miso_o
  );

  modport slave (
    input  spi_sck_i,
    input  spi_cs_n_i,
    input  spi_mosi_i,
    output spi_miso_o
  );
endinterface

// File: rtl/gpio_spi_regs.sv
// SPI mode-0 register slave driving GPIO pad out/dir/pull vectors.
// The SPI pins are oversampled on clk; 40-bit frames: 8-bit command then 32 data bits.
`timescale 1ns/1ps
module gpio_spi_regs #(
  parameter int unsigned N_GPIO = 25,
  parameter logic [31:0] DEV_ID = 32'h564C_5349
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_spi_regs_if.slave    spi,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_dir,
  output logic [N_GPIO-1:0] gpio_pullen
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam logic [5:0] CMD_BITS   = 6'd8;
  localparam logic [5:0] FRAME_BITS = 6'd40;

  state_t            state;
  logic [2:0]        sck_sync;
  logic [1:0]        cs_n_sync;
  logic [1:0]        mosi_sync;
  logic [N_GPIO-1:0] gpio_in_meta;
  logic [N_GPIO-1:0] gpio_in_sync;
  logic              sck_rise;
  logic              sck_fall;
  logic              cs_n_s;
  logic              mosi_s;
  logic [5:0]        bit_cnt;
  logic [7:0]        cmd;
  logic [N_GPIO-1:0] rx_data;
  logic [30:0]       tx_shift;
  logic [31:0]       rd_data;
  logic              commit_pending;
  logic [7:0]        abort_cnt;
  logic              bad_addr;
  logic              miso_q;

  assign spi.spi_miso_o = miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync     <= '0;
      cs_n_sync    <= 2'b11;
      mosi_sync    <= '0;
      gpio_in_meta <= '0;
      gpio_in_sync <= '0;
    end else begin
      sck_sync     <= {sck_sync[1:0], spi.spi_sck_i};
      cs_n_sync    <= {cs_n_sync[0], spi.spi_cs_n_i};
      mosi_sync    <= {mosi_sync[0], spi.spi_mosi_i};
      gpio_in_meta <= gpio_in;
      gpio_in_sync <= gpio_in_meta;
    end
  end

  // mosi goes through the same depth as sck, so the sampled bit lines up with the detected rise
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign cs_n_s   = cs_n_sync[1];
  assign mosi_s   = mosi_sync[1];

  always_comb begin
    rd_data = '0;
    case (cmd[6:0])
      7'h00:   rd_data[N_GPIO-1:0] = gpio_out;
      7'h01:   rd_data[N_GPIO-1:0] = gpio_dir;
      7'h02:   rd_data[N_GPIO-1:0] = gpio_pullen;
      7'h03:   rd_data[N_GPIO-1:0] = gpio_in_sync;
      7'h04:   rd_data = DEV_ID;
      7'h05:   rd_data = {23'd0, bad_addr, abort_cnt};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      cmd            <= '0;
      rx_data        <= '0;
      tx_shift       <= '0;
      miso_q         <= 1'b0;
      commit_pending <= 1'b0;
      abort_cnt      <= '0;
      bad_addr       <= 1'b0;
      gpio_out       <= '0;
      gpio_dir       <= '1;
      gpio_pullen    <= '0;
    end else begin
      commit_pending <= 1'b0;

      // Commit runs even if cs_n rises this cycle: the frame was already complete
      if (commit_pending) begin
        if (cmd[7]) begin
          if (cmd[6:0] > 7'h05) bad_addr <= 1'b1;
        end else begin
          case (cmd[6:0])
            7'h00:   gpio_out    <= rx_data;
            7'h01:   gpio_dir    <= rx_data;
            7'h02:   gpio_pullen <= rx_data;
            7'h05: begin
              abort_cnt <= '0;
              bad_addr  <= 1'b0;
            end
            default: bad_addr <= 1'b1;
          endcase
        end
      end

      if (cs_n_s) begin
        if (bit_cnt != 6'd0 && bit_cnt != FRAME_BITS && abort_cnt != 8'hFF)
          abort_cnt <= abort_cnt + 8'd1;
        state   <= IDLE;
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CMD;
          CMD, DATA: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt < CMD_BITS) cmd <= {cmd[6:0], mosi_s};
              else rx_data <= N_GPIO'({rx_data, mosi_s});
              if (bit_cnt == CMD_BITS - 6'd1) state <= DATA;
              if (bit_cnt == FRAME_BITS - 6'd1) begin
                state          <= DONE;
                commit_pending <= 1'b1;
                miso_q         <= 1'b0;
              end
            end
            // tx_shift holds the bits still to be sent after the one already on MISO
            if (sck_fall && state == DATA && cmd[7]) begin
              if (bit_cnt == CMD_BITS) begin
                miso_q   <= rd_data[31];
                tx_shift <= rd_data[30:0];
              end else if (bit_cnt < FRAME_BITS) begin
                miso_q   <= tx_shift[30];
                tx_shift <= {tx_shift[29:0], 1'b0};
              end
            end
          end
          DONE: miso_q <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_spi_regs.sv
// Randomised bench for gpio_spi_regs: a host driver issues SPI frames, a pad-level
// monitor scores every complete MISO word against a register-map reference model.
`timescale 1ns/1ps
module tb_gpio_spi_regs;

  localparam int          N      = 25;
  localparam logic [31:0] DEV_ID = 32'h564C_5349;
  localparam logic [31:0] MASK   = 32'h01FF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] gpio_in;
  logic [N-1:0] gpio_out;
  logic [N-1:0] gpio_dir;
  logic [N-1:0] gpio_pullen;

  gpio_spi_regs_if spi_bus ();

  gpio_spi_regs #(.N_GPIO(N), .DEV_ID(DEV_ID)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi_bus.slave),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_dir    (gpio_dir),
    .gpio_pullen (gpio_pullen)
  );

  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];

  // Reference model: architectural register contents only
  logic [31:0] m_out;
  logic [31:0] m_dir;
  logic [31:0] m_pull;
  int          m_abort;
  bit          m_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_out   = '0;
    m_dir   = MASK;
    m_pull  = '0;
    m_abort = 0;
    m_bad   = 1'b0;
  endtask

  function automatic logic [31:0] modelRead(input logic [6:0] addr);
    case (addr)
      7'h00:   return m_out;
      7'h01:   return m_dir;
      7'h02:   return m_pull;
      7'h03:   return 32'(gpio_in);
      7'h04:   return DEV_ID;
      7'h05:   return {23'd0, m_bad, 8'(m_abort)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelCommit(input logic [7:0] cmd, input logic [31:0] data);
    if (cmd[7]) begin
      if (cmd[6:0] > 7'h05) m_bad = 1'b1;
    end else begin
      case (cmd[6:0])
        7'h00:   m_out  = data & MASK;
        7'h01:   m_dir  = data & MASK;
        7'h02:   m_pull = data & MASK;
        7'h05: begin
          m_abort = 0;
          m_bad   = 1'b0;
        end
        default: m_bad = 1'b1;
      endcase
    end
  endtask

  task automatic sckWait();
    repeat ($urandom_range(5, 7)) @(posedge clk);
    #($urandom_range(1, 8));
  endtask

  task automatic checkOutput();
    @(posedge clk);
    #1;
    check("gpio_out",    32'(gpio_out),    m_out);
    check("gpio_dir",    32'(gpio_dir),    m_dir);
    check("gpio_pullen", 32'(gpio_pullen), m_pull);
    check("miso_idle",   32'(spi_bus.spi_miso_o), 32'h0);
  endtask

  // Drive one frame of nbits; a complete frame posts its expected MISO word first
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] data,
                               input int nbits, input bit do_reset);
    logic [39:0] frame;
    logic [31:0] nv_out, nv_dir, nv_pull;
    bit          complete;
    frame    = {cmd, data};
    complete = (nbits >= 40) && !do_reset;
    if (complete) exp_q.push_back(cmd[7] ? modelRead(cmd[6:0]) : 32'h0);
    sckWait();
    spi_bus.spi_cs_n_i = 1'b0;
    sckWait();
    for (int i = 0; i < nbits; i++) begin
      spi_bus.spi_mosi_i = (i < 40) ? frame[39 - i] : 1'($urandom_range(0, 1));
      sckWait();
      spi_bus.spi_sck_i = 1'b1;
      if (i == 39 && complete && !cmd[7] && cmd[6:0] <= 7'h02) begin
        nv_out  = (cmd[6:0] == 7'h00) ? (data & MASK) : m_out;
        nv_dir  = (cmd[6:0] == 7'h01) ? (data & MASK) : m_dir;
        nv_pull = (cmd[6:0] == 7'h02) ? (data & MASK) : m_pull;
        repeat (3) @(posedge clk);
        #1;
        check("precommit_out",  32'(gpio_out),    m_out);
        check("precommit_dir",  32'(gpio_dir),    m_dir);
        check("precommit_pull", 32'(gpio_pullen), m_pull);
        @(posedge clk);
        #1;
        check("commit_out",  32'(gpio_out),    nv_out);
        check("commit_dir",  32'(gpio_dir),    nv_dir);
        check("commit_pull", 32'(gpio_pullen), nv_pull);
      end
      sckWait();
      spi_bus.spi_sck_i = 1'b0;
    end
    sckWait();
    if (do_reset) begin
      rst_n = 1'b0;
      #3;
      spi_bus.spi_cs_n_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
    end else begin
      spi_bus.spi_cs_n_i = 1'b1;
      if (complete) modelCommit(cmd, data);
      else if (nbits > 0 && m_abort < 255) m_abort++;
    end
    repeat (4) @(posedge clk);
  endtask

  // Pad-level monitor: MISO is sampled on host sck rises 9..40 of each frame
  initial begin : monitor
    int          mon_cnt;
    logic [31:0] mon_word;
    logic [31:0] exp;
    mon_cnt  = 0;
    mon_word = '0;
    forever begin
      @(posedge spi_bus.spi_sck_i or posedge spi_bus.spi_cs_n_i);
      if (spi_bus.spi_cs_n_i === 1'b1) begin
        if (mon_cnt >= 40) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL miso_word: unexpected frame, got %h expected none", mon_word);
          end else begin
            exp = exp_q.pop_front();
            check("miso_word", mon_word, exp);
          end
        end
        mon_cnt = 0;
      end else begin
        mon_cnt++;
        if (mon_cnt >= 9 && mon_cnt <= 40) mon_word = {mon_word[30:0], spi_bus.spi_miso_o};
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [7:0] cmd;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    gpio_in = '0;
    spi_bus.spi_sck_i  = 1'b0;
    spi_bus.spi_cs_n_i = 1'b1;
    spi_bus.spi_mosi_i = 1'b0;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_out",  32'(gpio_out),    32'h0);
    check("reset_dir",  32'(gpio_dir),    32'h01FF_FFFF);
    check("reset_pull", 32'(gpio_pullen), 32'h0);
    check("reset_miso", 32'(spi_bus.spi_miso_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput();
    applyStimulus(8'h85, $urandom, 40, 1'b0);

    applyStimulus(8'h01, 32'h0000_00FF, 40, 1'b0);
    applyStimulus(8'h00, 32'h0000_00A5, 40, 1'b0);
    checkOutput();
    applyStimulus(8'h80, $urandom, 40, 1'b0);
    applyStimulus(8'h84, $urandom, 40, 1'b0);
    gpio_in = 25'h1234567;
    applyStimulus(8'h83, $urandom, 40, 1'b0);

    applyStimulus(8'h02, 32'hFFFF_FFFF, 20, 1'b0);
    checkOutput();
    applyStimulus(8'h85, $urandom, 40, 1'b0);
    applyStimulus(8'h07, $urandom, 40, 1'b0);
    applyStimulus(8'h85, $urandom, 40, 1'b0);
    applyStimulus(8'h05, $urandom, 40, 1'b0);
    applyStimulus(8'h85, $urandom, 40, 1'b0);
    applyStimulus(8'h04, 32'hDEAD_BEEF, 40, 1'b0);
    applyStimulus(8'hFF, $urandom, 40, 1'b0);
    applyStimulus(8'h85, $urandom, 40, 1'b0);
    applyStimulus(8'h05, 32'h0, 40, 1'b0);
    applyStimulus(8'h00, $urandom, 0, 1'b0);
    applyStimulus(8'h85, $urandom, 40, 1'b0);

    for (int k = 0; k < 20; k++) begin
      gpio_in = N'($urandom);
      cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
      applyStimulus(cmd, $urandom, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 39) : 40, 1'b0);
      checkOutput();
    end

    applyStimulus(8'h00, $urandom, 48, 1'b0);
    checkOutput();

    applyStimulus(8'h05, 32'h0, 40, 1'b0);
    for (int k = 0; k < 256; k++)
      applyStimulus(8'($urandom), $urandom, $urandom_range(1, 3), 1'b0);
    applyStimulus(8'h85, $urandom, 40, 1'b0);
    applyStimulus(8'h05, 32'h0, 40, 1'b0);

    applyStimulus(8'h00, 32'h0000_01AB, 40, 1'b0);
    applyStimulus(8'h00, 32'hFFFF_FFFF, 30, 1'b1);
    checkOutput();
    applyStimulus(8'h00, 32'h0000_0155, 40, 1'b0);
    checkOutput();
    applyStimulus(8'h80, $urandom, 40, 1'b0);
    applyStimulus(8'h85, $urandom, 40, 1'b0);

    repeat (10) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
